// File: rtl/tffcnt_pkg.sv
// Shared definitions for the T-flip-flop up/down counter: direction constants,
// the priority-select encoding for clr/load/en and the modulo next-count helper.
// Arithmetic is carried out one bit wider than the count so no wrap can overflow.
package tffcnt_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Widest count supported by next_count; callers truncate to their own width.
    localparam int CNT_MAX_W = 32;

    typedef enum logic [1:0] {
        SEL_HOLD = 2'd0,
        SEL_STEP = 2'd1,
        SEL_LOAD = 2'd2,
        SEL_CLR  = 2'd3
    } sel_e;

    // clr beats load, load beats en, otherwise hold.
    function automatic sel_e prio_sel(input logic clr, input logic load, input logic en);
        sel_e sel;
        if (clr)       sel = SEL_CLR;
        else if (load) sel = SEL_LOAD;
        else if (en)   sel = SEL_STEP;
        else           sel = SEL_HOLD;
        return sel;
    endfunction

    // One modulo step in the given direction, computed one bit wider than the
    // count so the +1 at the top of a full-range counter cannot lose its carry.
    function automatic logic [CNT_MAX_W:0] next_count(input logic [CNT_MAX_W-1:0] count,
                                                      input logic                 up,
                                                      input logic [CNT_MAX_W-1:0] modulus);
        logic [CNT_MAX_W:0] cnt_w;
        logic [CNT_MAX_W:0] mod_w;
        logic [CNT_MAX_W:0] one_w;
        logic [CNT_MAX_W:0] res;
        cnt_w = {1'b0, count};
        mod_w = {1'b0, modulus};
        one_w = (CNT_MAX_W+1)'(1);
        if (up == DIR_UP) begin
            res = ((cnt_w + one_w) == mod_w) ? '0 : (cnt_w + one_w);
        end else begin
            res = (cnt_w == '0) ? (mod_w - one_w) : (cnt_w - one_w);
        end
        return res;
    endfunction

endpackage

// File: rtl/tffcnt_cell.sv
// Single toggle flip-flop: state inverts on a rising clk edge when t is high.
// Latency: one clock from t to q; reset_n low clears q immediately.
// No backpressure: the cell accepts a toggle request every cycle.
module tffcnt_cell (
    input  logic clk,
    input  logic reset_n,
    input  logic t,
    output logic q,
    output logic qb
);

    logic q_q;
    logic q_d;

    // Next state is the current state flipped when a toggle is requested.
    always_comb begin
        q_d = q_q ^ t;
    end

    // State register with asynchronous active-low clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q  = q_q;
    assign qb = ~q_q;

endmodule

// File: rtl/tff_updown_counter.sv
// Modulo-MODULUS up/down counter whose bits are T cells fed with count ^ next.
// Latency: count moves one clock after the enabling edge; tc is same-cycle
// combinational, wrap is a registered pulse the cycle after a wrapping edge.
// No backpressure: one step per clock while en is high.
// Build option TFFCNT_SATURATE_EN: hold at the bounds instead of wrapping and
// pulse wrap whenever an enabled step is blocked there.
module tff_updown_counter
    import tffcnt_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             up,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap
);

    if (WIDTH < 1 || WIDTH > CNT_MAX_W || MODULUS < 2 ||
        longint'(MODULUS) > (longint'(1) << WIDTH)) begin : g_bad_params
        $error("tff_updown_counter: need 2 <= MODULUS <= 2**WIDTH and 1 <= WIDTH <= 32");
    end

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);

    sel_e             sel;
    logic             at_top;
    logic             at_bot;
    logic             at_bound;
    logic [WIDTH-1:0] stepped;
    logic [WIDTH-1:0] nxt_cnt;
    logic [WIDTH-1:0] tgl;
    logic [WIDTH-1:0] cell_qb_unused;
    logic             wrap_q;
    logic             wrap_d;

    // Decode the bound conditions, pick the next count by priority and derive
    // the per-bit toggle enables that move the T cells to it.
    always_comb begin
        sel      = prio_sel(clr, load, en);
        at_top   = (count == MAX_VAL);
        at_bot   = (count == '0);
        at_bound = (up == DIR_UP) ? at_top : at_bot;
        stepped  = WIDTH'(next_count(CNT_MAX_W'(count), up, CNT_MAX_W'(MODULUS)));
        nxt_cnt  = count;
        wrap_d   = 1'b0;
        case (sel)
            SEL_CLR: begin
                nxt_cnt = '0;
            end
            SEL_LOAD: begin
                nxt_cnt = ({1'b0, load_val} >= MOD_EXT) ? MAX_VAL : load_val;
            end
            SEL_STEP: begin
`ifdef TFFCNT_SATURATE_EN
                nxt_cnt = at_bound ? count : stepped;
                wrap_d  = at_bound;
`else
                nxt_cnt = stepped;
                wrap_d  = at_bound;
`endif
            end
            default: begin
                nxt_cnt = count;
            end
        endcase
        tgl = count ^ nxt_cnt;
    end

    // Terminal count doubles as the enable of the next cascaded digit.
    always_comb begin
        tc = en & (((up == DIR_UP) & at_top) | ((up == DIR_DOWN) & at_bot));
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        tffcnt_cell u_cell (
            .clk     (clk),
            .reset_n (reset_n),
            .t       (tgl[i]),
            .q       (count[i]),
            .qb      (cell_qb_unused[i])
        );
    end

    // Wrap / saturation pulse register, cleared asynchronously with the count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= wrap_d;
        end
    end

    assign wrap = wrap_q;

endmodule
